// File: rtl/rc_sw_alloc_pkg.sv
// Shared NoC router constants: port indices, direction codes,
// and the direction code that selects each output port.
package rc_sw_alloc_pkg;

  localparam int NPORT = 5;
  localparam int PW    = 3;

  localparam int P_YP  = 0;
  localparam int P_XP  = 1;
  localparam int P_YM  = 2;
  localparam int P_XM  = 3;
  localparam int P_LOC = 4;

  localparam logic [3:0] DIR_YP   = 4'b0001;
  localparam logic [3:0] DIR_XP   = 4'b0010;
  localparam logic [3:0] DIR_YM   = 4'b0100;
  localparam logic [3:0] DIR_XM   = 4'b1000;
  localparam logic [3:0] DIR_LOC  = 4'b0000;
  localparam logic [3:0] DIR_NONE = 4'b1111;

  localparam logic [PW-1:0] P_LAST = PW'(NPORT - 1);
  localparam logic [PW:0]   NP_W   = (PW + 1)'(NPORT);

  function automatic logic [3:0] port_dir(input int p);
    logic [3:0] d;
    d = DIR_LOC;
    case (p)
      P_YP:    d = DIR_YP;
      P_XP:    d = DIR_XP;
      P_YM:    d = DIR_YM;
      P_XM:    d = DIR_XM;
      default: d = DIR_LOC;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rc_sw_alloc_rr_arb5.sv
// Five-way round-robin arbiter with its own pointer register;
// the enable gates all grants (used for credit availability).
module rr_arb5
  import rc_sw_alloc_pkg::*;
(
  input  logic             rc_clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req,
  input  logic             en,
  output logic [NPORT-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             vld
);

  logic [PW-1:0] ptr;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int k = 0; k < NPORT; k++) begin
      sum = {1'b0, ptr} + (PW + 1)'(k);
      if (sum >= NP_W) begin
        sum = sum - NP_W;
      end
      cand = sum[PW-1:0];
      if (!vld && en && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
    if (vld) begin
      gnt[idx] = 1'b1;
    end
  end

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (vld) begin
      ptr <= (idx == P_LAST) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/rc_sw_alloc.sv
// 5-port mesh router switch allocator: request decode, per-output
// round-robin arbitration gated by downstream credits, registered xbar select.
module rc_sw_alloc
  import rc_sw_alloc_pkg::*;
#(
  parameter int CREDIT_MAX = 4,
  parameter int CW         = 3
) (
  input  logic                rc_clk,
  input  logic                rst_n,
  input  logic [NPORT-1:0]    req_valid_i,
  input  logic [4*NPORT-1:0]  req_dir_i,
  output logic [NPORT-1:0]    gnt_o,
  input  logic [NPORT-1:0]    credit_ret_i,
  output logic [NPORT-1:0]    out_valid_o,
  output logic [PW*NPORT-1:0] out_sel_o,
  output logic [CW*NPORT-1:0] credit_o,
  output logic                err_o
);

  localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

  logic [NPORT-1:0] req_m [NPORT];
  logic [NPORT-1:0] arb_gnt [NPORT];
  logic [PW-1:0]    arb_idx [NPORT];
  logic [NPORT-1:0] arb_vld;
  logic [CW-1:0]    cred [NPORT];
  logic [PW-1:0]    sel_q [NPORT];
  logic [NPORT-1:0] valid_q;
  logic             err_q;
  logic             dec_err;
  logic             ret_ovf;
  logic [3:0]       d;
  logic             hit;
  logic [NPORT-1:0] g_any;

  // req_m[o][i]: input i wants output o
  always_comb begin
    dec_err = 1'b0;
    d       = '0;
    hit     = 1'b0;
    for (int o = 0; o < NPORT; o++) begin
      req_m[o] = '0;
    end
    for (int i = 0; i < NPORT; i++) begin
      d   = req_dir_i[4*i +: 4];
      hit = 1'b0;
      if (req_valid_i[i] && d != DIR_NONE) begin
        for (int o = 0; o < NPORT; o++) begin
          if (d == port_dir(o)) begin
            hit = 1'b1;
            if (o == i && o != P_LOC) begin
              dec_err = 1'b1;
            end else begin
              req_m[o][i] = 1'b1;
            end
          end
        end
        if (!hit) begin
          dec_err = 1'b1;
        end
      end
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arb5 u_arb (
      .rc_clk (rc_clk),
      .rst_n  (rst_n),
      .req    (req_m[o]),
      .en     (cred[o] != '0),
      .gnt    (arb_gnt[o]),
      .idx    (arb_idx[o]),
      .vld    (arb_vld[o])
    );
  end

  always_comb begin
    g_any   = '0;
    ret_ovf = 1'b0;
    for (int o = 0; o < NPORT; o++) begin
      g_any = g_any | arb_gnt[o];
      if (credit_ret_i[o] && !arb_vld[o] && cred[o] == CMAX) begin
        ret_ovf = 1'b1;
      end
    end
    gnt_o = rst_n ? g_any : '0;
  end

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int o = 0; o < NPORT; o++) begin
        cred[o]  <= CMAX;
        sel_q[o] <= '0;
      end
    end else begin
      valid_q <= arb_vld;
      err_q   <= err_q | dec_err | ret_ovf;
      for (int o = 0; o < NPORT; o++) begin
        if (arb_vld[o]) begin
          sel_q[o] <= arb_idx[o];
        end
        case ({arb_vld[o], credit_ret_i[o]})
          2'b10:   cred[o] <= cred[o] - 1'b1;
          2'b01:   cred[o] <= (cred[o] == CMAX) ? CMAX : cred[o] + 1'b1;
          default: cred[o] <= cred[o];
        endcase
      end
    end
  end

  always_comb begin
    out_sel_o = '0;
    credit_o  = '0;
    for (int o = 0; o < NPORT; o++) begin
      out_sel_o[PW*o +: PW] = sel_q[o];
      credit_o[CW*o +: CW]  = cred[o];
    end
  end

  assign out_valid_o = valid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_rc_sw_alloc.sv
// Directed bench for rc_sw_alloc with a per-cycle reference model
// of arbitration, credits and the sticky error flag.
module tb_rc_sw_alloc;

  logic        rc_clk;
  logic        rst_n;
  logic [4:0]  req_valid_i;
  logic [19:0] req_dir_i;
  logic [4:0]  gnt_o;
  logic [4:0]  credit_ret_i;
  logic [4:0]  out_valid_o;
  logic [14:0] out_sel_o;
  logic [14:0] credit_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  rc_sw_alloc dut (
    .rc_clk       (rc_clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_dir_i    (req_dir_i),
    .gnt_o        (gnt_o),
    .credit_ret_i (credit_ret_i),
    .out_valid_o  (out_valid_o),
    .out_sel_o    (out_sel_o),
    .credit_o     (credit_o),
    .err_o        (err_o)
  );

  initial rc_clk = 1'b0;
  always #5 rc_clk = ~rc_clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  // reference model state
  int         m_cred [5];
  int         m_ptr  [5];
  int         m_sel  [5];
  logic [4:0] m_ov;
  logic       m_err;

  int         win [5];
  logic [4:0] reqs [5];
  logic [4:0] exp_g;
  logic [14:0] exp_sel;
  logic [14:0] exp_cred;
  logic       nerr;
  logic [3:0] dd;
  int         t;
  int         c;

  function automatic int dir2port(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      4'b0000: return 4;
      default: return -1;
    endcase
  endfunction

  always @(negedge rc_clk) begin
    if (!rst_n) begin
      for (int o = 0; o < 5; o++) begin
        m_cred[o] = 4;
        m_ptr[o]  = 0;
        m_sel[o]  = 0;
      end
      m_ov  = '0;
      m_err = 1'b0;
      chk("rst_gnt", gnt_o, 0);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_sel", out_sel_o, 0);
      chk("rst_credit", credit_o, {5{3'd4}});
      chk("rst_err", err_o, 0);
    end else begin
      nerr = m_err;
      for (int o = 0; o < 5; o++) reqs[o] = '0;
      for (int i = 0; i < 5; i++) begin
        dd = req_dir_i[4*i +: 4];
        if (req_valid_i[i] && dd != 4'b1111) begin
          t = dir2port(dd);
          if (t < 0 || (t == i && t != 4)) nerr = 1'b1;
          else reqs[t][i] = 1'b1;
        end
      end
      exp_g = '0;
      for (int o = 0; o < 5; o++) begin
        win[o] = -1;
        if (m_cred[o] > 0) begin
          for (int k = 0; k < 5; k++) begin
            c = (m_ptr[o] + k) % 5;
            if (win[o] < 0 && reqs[o][c]) win[o] = c;
          end
        end
        if (win[o] >= 0) exp_g[win[o]] = 1'b1;
      end
      exp_sel  = '0;
      exp_cred = '0;
      for (int o = 0; o < 5; o++) begin
        exp_sel[3*o +: 3]  = 3'(m_sel[o]);
        exp_cred[3*o +: 3] = 3'(m_cred[o]);
      end
      chk("gnt", gnt_o, exp_g);
      chk("out_valid", out_valid_o, m_ov);
      chk("out_sel", out_sel_o, exp_sel);
      chk("credit", credit_o, exp_cred);
      chk("err", err_o, m_err);
      for (int o = 0; o < 5; o++) begin
        if (win[o] >= 0 && !credit_ret_i[o]) begin
          m_cred[o]--;
        end else if (win[o] < 0 && credit_ret_i[o]) begin
          if (m_cred[o] == 4) nerr = 1'b1;
          else m_cred[o]++;
        end
        m_ov[o] = (win[o] >= 0);
        if (win[o] >= 0) begin
          m_sel[o] = win[o];
          m_ptr[o] = (win[o] + 1) % 5;
        end
      end
      m_err = nerr;
    end
  end

  task automatic step();
    @(posedge rc_clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid_i  = '0;
    req_dir_i    = '0;
    credit_ret_i = '0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge rc_clk);
    chk("lit_reset_credit", credit_o, 15'h4924);
    chk("lit_reset_valid", out_valid_o, 0);

    // single LOCAL->X+ request
    step();
    req_valid_i       = 5'b10000;
    req_dir_i[19:16]  = 4'b0010;
    @(negedge rc_clk);
    chk("lit_single_gnt", gnt_o, 5'b10000);
    step();
    req_valid_i = '0;
    @(negedge rc_clk);
    chk("lit_single_valid", out_valid_o[1], 1);
    chk("lit_single_sel", out_sel_o[5:3], 4);
    chk("lit_single_credit", credit_o[5:3], 3);

    step();
    credit_ret_i = 5'b00010;
    step();
    credit_ret_i = '0;

    // four contenders on X+, round-robin then credit exhaustion
    req_dir_i   = {5{4'b0010}};
    req_valid_i = 5'b11101;
    @(negedge rc_clk);
    chk("lit_rr0", gnt_o, 5'b00001);
    step();
    req_valid_i = 5'b11100;
    @(negedge rc_clk);
    chk("lit_rr2", gnt_o, 5'b00100);
    step();
    req_valid_i = 5'b11000;
    @(negedge rc_clk);
    chk("lit_rr3", gnt_o, 5'b01000);
    step();
    req_valid_i = 5'b10000;
    @(negedge rc_clk);
    chk("lit_rr4", gnt_o, 5'b10000);
    step();
    req_valid_i = 5'b11101;
    @(negedge rc_clk);
    chk("lit_nocred_gnt", gnt_o, 0);
    chk("lit_nocred_credit", credit_o[5:3], 0);
    step();
    credit_ret_i = 5'b00010;
    @(negedge rc_clk);
    chk("lit_ret_at0_gnt", gnt_o, 0);
    step();
    credit_ret_i = '0;
    @(negedge rc_clk);
    chk("lit_after_ret_gnt", gnt_o, 5'b00001);
    chk("lit_after_ret_credit", credit_o[5:3], 1);
    step();
    req_valid_i = '0;
    @(negedge rc_clk);
    chk("lit_end_credit", credit_o[5:3], 0);

    // grant and return together at credit 2
    step();
    credit_ret_i = 5'b00010;
    step();
    step();
    req_valid_i = 5'b00001;
    @(negedge rc_clk);
    chk("lit_both_gnt", gnt_o, 5'b00001);
    chk("lit_both_pre", credit_o[5:3], 2);
    step();
    req_valid_i  = '0;
    credit_ret_i = '0;
    @(negedge rc_clk);
    chk("lit_both_post", credit_o[5:3], 2);

    // idle code is silent
    step();
    req_valid_i     = 5'b00001;
    req_dir_i[3:0]  = 4'b1111;
    @(negedge rc_clk);
    chk("lit_none_gnt", gnt_o, 0);
    step();
    req_valid_i = '0;
    @(negedge rc_clk);
    chk("lit_none_err", err_o, 0);

    // illegal code
    step();
    req_valid_i    = 5'b00010;
    req_dir_i[7:4] = 4'b0110;
    @(negedge rc_clk);
    chk("lit_illegal_gnt", gnt_o, 0);
    step();
    req_valid_i = '0;
    @(negedge rc_clk);
    chk("lit_illegal_err", err_o, 1);
    step();
    step();
    @(negedge rc_clk);
    chk("lit_err_sticky", err_o, 1);
    do_reset();
    @(negedge rc_clk);
    chk("lit_err_cleared", err_o, 0);

    // U-turn
    step();
    req_valid_i    = 5'b00010;
    req_dir_i[7:4] = 4'b0010;
    @(negedge rc_clk);
    chk("lit_uturn_gnt", gnt_o, 0);
    step();
    req_valid_i = '0;
    @(negedge rc_clk);
    chk("lit_uturn_err", err_o, 1);
    do_reset();

    // return at full credit
    step();
    credit_ret_i = 5'b00100;
    step();
    credit_ret_i = '0;
    @(negedge rc_clk);
    chk("lit_ovf_err", err_o, 1);
    chk("lit_ovf_credit", credit_o[8:6], 4);
    do_reset();

    // reset in the middle of traffic
    step();
    req_dir_i[3:0]   = 4'b0000;
    req_dir_i[11:8]  = 4'b0000;
    req_valid_i      = 5'b00101;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("lit_midrst_valid", out_valid_o, 0);
    chk("lit_midrst_credit", credit_o, 15'h4924);
    step();
    rst_n = 1'b1;
    @(negedge rc_clk);
    chk("lit_midrst_first", gnt_o, 5'b00001);
    step();
    req_valid_i = '0;
    step();
    step();
    @(negedge rc_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
